// File: rtl/page_walker_pkg.sv
// page_walker_pkg: shared types and constants for the Sv32 page-table walker.
// Holds the broadcast result record, PTE bit positions and layout, the walk
// state encoding and the PTE address helper.
package page_walker_pkg;

    // Width of the rqID field carried in the broadcast result.
    localparam int PW_RQID_W = 2;

    // Sv32 PTE bit positions.
    localparam int PTE_V       = 0;
    localparam int PTE_R       = 1;
    localparam int PTE_W       = 2;
    localparam int PTE_X       = 3;
    localparam int PTE_U       = 4;
    localparam int PTE_G       = 5;
    localparam int PTE_A       = 6;
    localparam int PTE_D       = 7;
    localparam int PTE_PPN_LSB = 10;

    typedef struct packed {
        logic [21:0] ppn;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

    typedef struct packed {
        logic                 valid;
        logic                 busy;
        logic                 pageFault;
        logic [19:0]          vpn;
        logic [21:0]          ppn;
        logic [2:0]           rwx;
        logic                 isSuperPage;
        logic                 user;
        logic                 globl;
        logic [PW_RQID_W-1:0] rqID;
    } PageWalk_Res;

    // Walk state encoding, kept as plain constants for legacy compatibility.
    typedef logic [2:0] pw_state_t;
    localparam pw_state_t ST_IDLE  = 3'd0;
    localparam pw_state_t ST_REQ1  = 3'd1;
    localparam pw_state_t ST_WAIT1 = 3'd2;
    localparam pw_state_t ST_REQ0  = 3'd3;
    localparam pw_state_t ST_WAIT0 = 3'd4;
    localparam pw_state_t ST_DONE  = 3'd5;

    // Physical address of a PTE: table base page plus 4-byte index.
    function automatic logic [33:0] pte_addr(input logic [21:0] base_ppn,
                                             input logic [9:0]  idx);
        return {base_ppn, 12'h000} + {22'h0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/page_walker_pte_decode.sv
// page_walker_pte_decode: combinational Sv32 PTE decode shared by both levels.
// level=1 is the root table (superpage leaves allowed), level=0 the second.
// Optional macro PW_AD_CHECK_EN: leaves with A=0 fault and W is masked by D.
module page_walker_pte_decode
    import page_walker_pkg::*;
(
    input  logic [31:0] pte,
    input  logic        level,
    output logic        fault,
    output logic        leaf,
    output logic        super_misaligned,
    output logic [2:0]  rwx,
    output logic        user,
    output logic        globl
);

    logic invalid;
    logic ad_fault;
    logic unused_bits;

    // Rsw bits and the upper PPN never influence the decode.
    assign unused_bits = ^{pte[9:8], pte[31:20], pte[PTE_A], pte[PTE_D]};

    // Classify the PTE and extract its permission bits.
    always_comb begin
        invalid          = !pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W]);
        leaf             = pte[PTE_R] || pte[PTE_X];
        super_misaligned = level && leaf && (pte[PTE_PPN_LSB+9:PTE_PPN_LSB] != '0);
`ifdef PW_AD_CHECK_EN
        ad_fault         = leaf && !pte[PTE_A];
        rwx              = {pte[PTE_R], pte[PTE_W] && pte[PTE_D], pte[PTE_X]};
`else
        ad_fault         = 1'b0;
        rwx              = {pte[PTE_R], pte[PTE_W], pte[PTE_X]};
`endif
        fault            = invalid || (!level && !leaf) || ad_fault;
        user             = pte[PTE_U];
        globl            = pte[PTE_G];
    end

endmodule

// File: rtl/page_walker.sv
// page_walker: Sv32 hardware page-table walker serving NUM_RQ TLB clients.
// One walk at a time, single-outstanding PTE reads, one broadcast result per
// walk (OUT_pw.valid pulses for one cycle). Client 0 has highest priority.
// Optional macro PW_AD_CHECK_EN enables A/D checking in the PTE decode.
module page_walker
    import page_walker_pkg::*;
#(
    parameter int NUM_RQ = 2,
    parameter int RQID_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_RQ-1:0]      IN_rqValid,
    input  logic [NUM_RQ-1:0][19:0] IN_rqVpn,
    output logic [NUM_RQ-1:0]      OUT_rqReady,
    input  logic [21:0]            IN_satpPpn,
    output logic                   OUT_memValid,
    output logic [33:0]            OUT_memAddr,
    input  logic                   IN_memReady,
    input  logic                   IN_memResValid,
    input  logic [31:0]            IN_memResData,
    output PageWalk_Res            OUT_pw
);

    pw_state_t         state;
    logic [19:0]       vpn_q;
    logic [RQID_W-1:0] rq_id_q;
    logic [33:0]       mem_addr_q;
    PageWalk_Res       pw_q;
    PageWalk_Res       res_fin;

    logic [NUM_RQ-1:0] grant;
    logic [RQID_W-1:0] grant_idx;
    logic [19:0]       grant_vpn;
    logic              grant_found;
    logic              accept;

    pte_t              pte_in;
    logic              level_top;
    logic              dec_fault;
    logic              dec_leaf;
    logic              dec_misaligned;
    logic [2:0]        dec_rwx;
    logic              dec_user;
    logic              dec_globl;
    logic              walk_fault;

    assign pte_in    = pte_t'(IN_memResData);
    assign level_top = (state == ST_WAIT1);

    page_walker_pte_decode u_decode (
        .pte              (IN_memResData),
        .level            (level_top),
        .fault            (dec_fault),
        .leaf             (dec_leaf),
        .super_misaligned (dec_misaligned),
        .rwx              (dec_rwx),
        .user             (dec_user),
        .globl            (dec_globl)
    );

    assign walk_fault = dec_fault || dec_misaligned;

    // Fixed-priority arbiter: lowest-index valid client wins.
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_vpn   = '0;
        grant_found = 1'b0;
        for (int unsigned i = 0; i < NUM_RQ; i++) begin
            if (IN_rqValid[i] && !grant_found) begin
                grant_found = 1'b1;
                grant[i]    = 1'b1;
                grant_idx   = RQID_W'(i);
                grant_vpn   = IN_rqVpn[i];
            end
        end
    end

    assign OUT_rqReady  = (state == ST_IDLE && !rst) ? grant : '0;
    assign accept       = (state == ST_IDLE) && grant_found;
    assign OUT_memValid = (state == ST_REQ1) || (state == ST_REQ0);
    assign OUT_memAddr  = mem_addr_q;
    assign OUT_pw       = pw_q;

    // Result record loaded on the transition into DONE.
    always_comb begin
        res_fin             = pw_q;
        res_fin.valid       = 1'b1;
        res_fin.busy        = 1'b1;
        res_fin.pageFault   = walk_fault;
        res_fin.vpn         = vpn_q;
        res_fin.ppn         = walk_fault ? '0 : pte_in.ppn;
        res_fin.rwx         = walk_fault ? '0 : dec_rwx;
        res_fin.isSuperPage = !walk_fault && level_top;
        res_fin.user        = dec_user;
        res_fin.globl       = dec_globl;
        res_fin.rqID        = PW_RQID_W'(rq_id_q);
    end

    // Walk sequencer: accept, two-level PTE fetch, single-cycle result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            vpn_q      <= '0;
            rq_id_q    <= '0;
            mem_addr_q <= '0;
            pw_q       <= '0;
        end else begin
            pw_q.valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        vpn_q      <= grant_vpn;
                        rq_id_q    <= grant_idx;
                        mem_addr_q <= pte_addr(IN_satpPpn, grant_vpn[19:10]);
                        pw_q.busy  <= 1'b1;
                        state      <= ST_REQ1;
                    end
                end
                ST_REQ1: begin
                    if (IN_memReady) state <= ST_WAIT1;
                end
                ST_WAIT1: begin
                    if (IN_memResValid) begin
                        if (walk_fault || dec_leaf) begin
                            pw_q  <= res_fin;
                            state <= ST_DONE;
                        end else begin
                            mem_addr_q <= pte_addr(pte_in.ppn, vpn_q[9:0]);
                            state      <= ST_REQ0;
                        end
                    end
                end
                ST_REQ0: begin
                    if (IN_memReady) state <= ST_WAIT0;
                end
                ST_WAIT0: begin
                    if (IN_memResValid) begin
                        pw_q  <= res_fin;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    pw_q.busy <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_page_walker.sv
// tb_page_walker: directed self-checking bench for page_walker.
module tb_page_walker;
    import page_walker_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       IN_rqValid;
    logic [1:0][19:0] IN_rqVpn;
    logic [1:0]       OUT_rqReady;
    logic [21:0]      IN_satpPpn;
    logic             OUT_memValid;
    logic [33:0]      OUT_memAddr;
    logic             IN_memReady;
    logic             IN_memResValid;
    logic [31:0]      IN_memResData;
    PageWalk_Res      OUT_pw;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int n_hs     = 0;
    int n_valid  = 0;

    page_walker #(.NUM_RQ(2), .RQID_W(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .IN_rqValid     (IN_rqValid),
        .IN_rqVpn       (IN_rqVpn),
        .OUT_rqReady    (OUT_rqReady),
        .IN_satpPpn     (IN_satpPpn),
        .OUT_memValid   (OUT_memValid),
        .OUT_memAddr    (OUT_memAddr),
        .IN_memReady    (IN_memReady),
        .IN_memResValid (IN_memResValid),
        .IN_memResData  (IN_memResData),
        .OUT_pw         (OUT_pw)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (OUT_memValid && IN_memReady) n_hs <= n_hs + 1;
    end

    always @(negedge clk) begin
        if (OUT_pw.valid) n_valid <= n_valid + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic c, input logic [19:0] v, input string tag);
        logic ok;
        ok = 1'b0;
        IN_rqVpn[c]   = v;
        IN_rqValid[c] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            ok = OUT_rqReady[c];
            if (ok) acc_cyc = cyc;
            @(negedge clk);
            if (ok) break;
        end
        IN_rqValid[c] = 1'b0;
        check({tag, "_accept"}, ok, 1);
    endtask

    task automatic serve(input logic [33:0] exp_addr, input logic [31:0] data,
                         input logic respond, input string tag);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (OUT_memValid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check({tag, "_req_seen"}, ok, 1);
        if (ok) begin
            check({tag, "_addr"}, OUT_memAddr, exp_addr);
            IN_memReady = 1'b1;
            @(negedge clk);
            IN_memReady = 1'b0;
            if (respond) begin
                IN_memResValid = 1'b1;
                IN_memResData  = data;
                @(negedge clk);
                IN_memResValid = 1'b0;
            end
        end
    endtask

    task automatic wait_result(output PageWalk_Res r, output int lat, input string tag);
        logic ok;
        ok  = 1'b0;
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            if (OUT_pw.valid) begin
                ok  = 1'b1;
                lat = cyc - acc_cyc;
                break;
            end
            @(negedge clk);
        end
        r = OUT_pw;
        check({tag, "_result_seen"}, ok, 1);
    endtask

    task automatic check_res(input string tag, input PageWalk_Res r, input logic fault,
                             input logic sp, input logic [21:0] ppn, input logic [2:0] rwx,
                             input logic [1:0] rqid, input logic [19:0] vpn,
                             input logic chk_ug, input logic user, input logic globl);
        check({tag, "_valid"}, r.valid, 1);
        check({tag, "_fault"}, r.pageFault, fault);
        check({tag, "_ppn"}, r.ppn, ppn);
        check({tag, "_rwx"}, r.rwx, rwx);
        check({tag, "_rqid"}, r.rqID, rqid);
        check({tag, "_vpn"}, r.vpn, vpn);
        if (!fault) check({tag, "_super"}, r.isSuperPage, sp);
        if (chk_ug) begin
            check({tag, "_user"}, r.user, user);
            check({tag, "_globl"}, r.globl, globl);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        PageWalk_Res r;
        int          lat;
        int          hs0;
        int          nv0;
        logic [2:0]  exp_rwx_d0;

        rst            = 1'b1;
        IN_rqValid     = 2'b11;
        IN_rqVpn       = '0;
        IN_satpPpn     = 22'h00100;
        IN_memReady    = 1'b0;
        IN_memResValid = 1'b0;
        IN_memResData  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_rqready", OUT_rqReady, 2'b00);
        check("rst_memvalid", OUT_memValid, 0);
        check("rst_pw", OUT_pw, '0);
        @(negedge clk);
        rst        = 1'b0;
        IN_rqValid = 2'b00;
        @(negedge clk);

        // Two-level walk, 0-wait memory.
        IN_satpPpn = 22'h00100;
        issue(1'b1, 20'h12345, "t1");
        check("t1_busy", OUT_pw.busy, 1);
        serve(34'h000100120, 32'h00080001, 1'b1, "t1_l1");
        serve(34'h000200D14, 32'h0ABCD0CF, 1'b1, "t1_l0");
        wait_result(r, lat, "t1");
        check("t1_latency", lat, 5);
        check_res("t1", r, 1'b0, 1'b0, 22'h2AF34, 3'b111, 2'd1, 20'h12345, 1'b1, 1'b0, 1'b0);
        check("t1_busy_done", r.busy, 1);
        @(negedge clk);
        check("t1_valid_pulse", OUT_pw.valid, 0);
        check("t1_busy_clear", OUT_pw.busy, 0);
        check("t1_hold_ppn", OUT_pw.ppn, 22'h2AF34);

        // Superpage leaf at level 1 (A=0, D=0).
        hs0 = n_hs;
        issue(1'b0, 20'h0ABCD, "t2");
        serve(34'h0001000A8, 32'h1000000F, 1'b1, "t2_l1");
        wait_result(r, lat, "t2");
        check("t2_latency", lat, 3);
`ifdef PW_AD_CHECK_EN
        check_res("t2", r, 1'b1, 1'b0, 22'h0, 3'b000, 2'd0, 20'h0ABCD, 1'b0, 1'b0, 1'b0);
`else
        check_res("t2", r, 1'b0, 1'b1, 22'h40000, 3'b111, 2'd0, 20'h0ABCD, 1'b1, 1'b0, 1'b0);
`endif
        repeat (2) @(negedge clk);
        check("t2_one_read", n_hs - hs0, 1);
        check("t2_memvalid_idle", OUT_memValid, 0);

        // Misaligned superpage.
        IN_satpPpn = 22'h00300;
        issue(1'b1, 20'h00400, "t3");
        serve(34'h000300004, 32'h10000443, 1'b1, "t3_l1");
        wait_result(r, lat, "t3");
        check_res("t3", r, 1'b1, 1'b0, 22'h0, 3'b000, 2'd1, 20'h00400, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Simultaneous requests: client 0 first, client 1 after DONE.
        IN_satpPpn = 22'h00100;
        nv0        = n_valid;
        IN_rqVpn[0] = 20'h00800;
        IN_rqVpn[1] = 20'h00C00;
        IN_rqValid  = 2'b11;
        #1;
        check("t4_grant0", OUT_rqReady, 2'b01);
        @(negedge clk);
        IN_rqValid[0] = 1'b0;
        #1;
        check("t4_no_grant_busy", OUT_rqReady, 2'b00);
        serve(34'h000100008, 32'h001000FB, 1'b1, "t4_c0");
        wait_result(r, lat, "t4_c0");
        check_res("t4_c0", r, 1'b0, 1'b1, 22'h00400, 3'b101, 2'd0, 20'h00800, 1'b1, 1'b1, 1'b1);
        #1;
        check("t4_no_grant_done", OUT_rqReady, 2'b00);
        @(negedge clk);
        #1;
        check("t4_grant1", OUT_rqReady, 2'b10);
        @(negedge clk);
        IN_rqValid[1] = 1'b0;
        serve(34'h00010000C, 32'h002000FB, 1'b1, "t4_c1");
        wait_result(r, lat, "t4_c1");
        check_res("t4_c1", r, 1'b0, 1'b1, 22'h00800, 3'b101, 2'd1, 20'h00C00, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("t4_two_pulses", n_valid - nv0, 2);

        // Memory stall with a spurious response in REQ1; leaf W=1, D=0, A=1.
        issue(1'b0, 20'h12345, "t5");
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_stall_valid%0d", i), OUT_memValid, 1);
            check($sformatf("t5_stall_addr%0d", i), OUT_memAddr, 34'h000100120);
            IN_memResValid = (i == 1);
            IN_memResData  = 32'h0;
            @(negedge clk);
        end
        IN_memResValid = 1'b0;
        serve(34'h000100120, 32'h00080001, 1'b1, "t5_l1");
        serve(34'h000200D14, 32'h00048C4F, 1'b1, "t5_l0");
        wait_result(r, lat, "t5");
`ifdef PW_AD_CHECK_EN
        exp_rwx_d0 = 3'b101;
`else
        exp_rwx_d0 = 3'b111;
`endif
        check_res("t5", r, 1'b0, 1'b0, 22'h00123, exp_rwx_d0, 2'd0, 20'h12345, 1'b1, 1'b0, 1'b0);
        @(negedge clk);

        // Reset while waiting for the level-0 response.
        issue(1'b1, 20'h12345, "t6");
        serve(34'h000100120, 32'h00080001, 1'b1, "t6_l1");
        serve(34'h000200D14, 32'h0, 1'b0, "t6_l0");
        nv0            = n_valid;
        rst            = 1'b1;
        IN_memResValid = 1'b1;
        IN_memResData  = 32'h0ABCD0CF;
        @(negedge clk);
        rst            = 1'b0;
        IN_memResValid = 1'b0;
        check("t6_pw_cleared", OUT_pw, '0);
        check("t6_memvalid", OUT_memValid, 0);
        repeat (8) @(negedge clk);
        check("t6_no_pulse", n_valid - nv0, 0);
        check("t6_memvalid_idle", OUT_memValid, 0);

        // Walker recovers after reset.
        issue(1'b0, 20'h00800, "t7");
        serve(34'h000100008, 32'h001000FB, 1'b1, "t7_l1");
        wait_result(r, lat, "t7");
        check_res("t7", r, 1'b0, 1'b1, 22'h00400, 3'b101, 2'd0, 20'h00800, 1'b1, 1'b1, 1'b1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
